javk_mem_responder: RTL and testbench
=====================================

// Module: javk_mem_responder
// PURPOSE
//  Bus-slave memory at the far end of the JAVK CPU bus (addrbus/rw/databus).
//  Decodes its window, inserts programmable wait states, returns read data on
//  the shared tristate databus or commits write data into an internal byte array.
//  Sits between the CPU bus and on-chip RAM; ack paces the master.
// PARAMETERS
//  ADDR_BITS    12       window size = 2**ADDR_BITS bytes; offset = addrbus[ADDR_BITS-1:0]
//  BASE         16'h0000 window base; hit when addrbus[15:ADDR_BITS]==BASE[15:ADDR_BITS]
//  WAIT_STATES  2        extra cycles before ack, legal 0..15
//  WP_LIMIT     16'h0100 write-protect bound (offset), used only with JAVK_MEM_WP_EN
// PORTS
//  clk      in    1   clock, all state changes on posedge
//  rst      in    1   reset, synchronous, active-high
//  addrbus  in    16  master address
//  rw       in    1   1=read, 0=write
//  req      in    1   master access strobe, held high until ack seen
//  databus  inout 8   shared data bus; driven only during own read ack
//  ack      out   1   registered: access complete (read data valid / write done)
//  hit      out   1   combinational: addrbus inside window
//  wp_err   out   1   sticky write-protect violation flag
// BEHAVIOUR
//  Reset: state=IDLE, ack=0, databus=Z, wp_err=0, wait count=0; array NOT cleared.
//  Reset mid-access: abandons access after that edge; no pending write commits.
//  FSM (posedge):
//   IDLE: req&&hit -> latch offset, rw, cnt=WAIT_STATES; go WAIT. Else stay.
//         req&&!hit: ignored (ack=0, databus Z).
//   WAIT: cnt==0 -> go DONE; else cnt<=cnt-1.
//         On DONE-entry edge: read -> rdata<=mem[offset]; write -> mem[offset]<=databus.
//   DONE: ack=1; databus=rdata iff latched rw=1, else Z. Stay while req=1;
//         req=0 -> IDLE, ack=0, databus released same edge.
//  Latency: req sampled at edge N -> ack high after edge N+2+WAIT_STATES.
//  Changes to addrbus/rw/req-data after latch are ignored; latched values rule.
//  Write data sampled only at DONE-entry edge; master holds databus until ack.
//  Back-to-back: req must drop for >=1 edge (DONE->IDLE) before next access.
//  Offset wraps within window only via decode; addresses outside never hit.
//  Never drives databus when rw=0, in IDLE/WAIT, or while rst is high.
// CONFIGURATION
//  JAVK_MEM_WP_EN defined: writes with offset < WP_LIMIT are discarded but still
//   acked normally; wp_err set at DONE-entry edge, held until rst.
//  Not defined: all writes commit; wp_err tied 0; WP_LIMIT unused.
// TESTING
//  1 W=2: preload mem[0x010]=8'hA5, req rw=1 addr 16'h0010 at edge 0
//    -> ack after edge 4, databus=8'hA5; req low -> ack 0, databus Z next edge.
//  2 Write 8'h3C to 16'h0123, then read 16'h0123 -> read returns 8'h3C.
//  3 req rw=1 addr 16'h2000 (BASE=0, ADDR_BITS=12) -> hit=0, ack stays 0,
//    databus Z for 20 cycles.
//  4 Start write to 16'h0040 data 8'hFF, assert rst in WAIT -> ack 0, databus Z;
//    later read 16'h0040 returns prior contents.
//  5 WP_EN, WP_LIMIT=16'h0100: write 8'h55 to 16'h0080 -> acked, wp_err=1,
//    mem unchanged; write to 16'h0100 -> commits.
//  6 W=0: two reads 16'h0000/16'h0001 separated by one req-low cycle
//    -> each ack after edge N+2, correct data each.

Source files
------------

// File: rtl/javk_mem_responder_if.sv
// JAVK CPU bus signal bundle (address, direction, strobe and responder status).
// The shared 8-bit databus is a tristate net and travels as a separate inout port.
interface javk_mem_responder_if;
   logic [15:0] addrbus;
   logic        rw;
   logic        req;
   logic        ack;
   logic        hit;
   logic        wp_err;

   modport master (
      output addrbus, rw, req,
      input  ack, hit, wp_err
   );

   modport slave (
      input  addrbus, rw, req,
      output ack, hit, wp_err
   );
endinterface

// File: rtl/javk_mem_responder.sv
// JAVK bus-slave memory with programmable wait states and a tristate read path.
// Optional write protection of low offsets is enabled with `define JAVK_MEM_WP_EN.
module javk_mem_responder #(
   parameter int          ADDR_BITS   = 12,
   parameter logic [15:0] BASE        = 16'h0000,
   parameter int          WAIT_STATES = 2
`ifdef JAVK_MEM_WP_EN
   ,parameter logic [15:0] WP_LIMIT   = 16'h0100
`endif
) (
   input  logic                      clk,
   input  logic                      rst,
   javk_mem_responder_if.slave       bus,
   inout  wire  [7:0]                databus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t               state;
   logic [3:0]           cnt;
   logic [ADDR_BITS-1:0] off_q;
   logic                 rw_q;
   logic [7:0]           rdata_q;
   logic                 ack_q;
   logic                 done_entry;
   logic                 wp_viol;
   logic                 mem_we;

   logic [7:0] mem [0:(1 << ADDR_BITS) - 1];

   assign bus.hit = (bus.addrbus[15:ADDR_BITS] == BASE[15:ADDR_BITS]);
   assign bus.ack = ack_q;

   // The access completes on the edge that leaves WAIT with the counter exhausted.
   assign done_entry = (state == S_WAIT) && (cnt == 4'd0);

`ifdef JAVK_MEM_WP_EN
   logic wp_err_q;

   assign wp_viol    = !rw_q && (16'(off_q) < WP_LIMIT);
   assign bus.wp_err = wp_err_q;

   always_ff @(posedge clk) begin
      if (rst)
         wp_err_q <= 1'b0;
      else if (done_entry && wp_viol)
         wp_err_q <= 1'b1;
   end
`else
   assign wp_viol    = 1'b0;
   assign bus.wp_err = 1'b0;
`endif

   // rst gates the commit so an access interrupted by reset never lands.
   assign mem_we = done_entry && !rw_q && !wp_viol && !rst;

   // NOTE: the array has no reset branch on purpose; contents survive rst and a
   // reset term here would also prevent mapping onto a RAM macro.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[off_q] <= databus;
   end

   // NOTE: every register below uses non-blocking assignment so all state
   // updates see pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
         ack_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               ack_q <= 1'b0;
               if (bus.req && bus.hit) begin
                  off_q <= bus.addrbus[ADDR_BITS-1:0];
                  rw_q  <= bus.rw;
                  cnt   <= 4'(WAIT_STATES);
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) begin
                  if (rw_q)
                     rdata_q <= mem[off_q];
                  state <= S_DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_DONE: begin
               // ack rises one edge after DONE entry and drops with req.
               if (bus.req) begin
                  ack_q <= 1'b1;
               end else begin
                  ack_q <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
               ack_q <= 1'b0;
            end
         endcase
      end
   end

   assign databus = (ack_q && rw_q && !rst) ? rdata_q : 8'bz;

endmodule

// File: tb/tb_javk_mem_responder.sv
// Directed bench for javk_mem_responder: a WAIT_STATES=2 instance and a zero-wait
// instance; data nets are pulled high so a released bus reads 8'hFF.
module tb_javk_mem_responder;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   javk_mem_responder_if bif ();
   javk_mem_responder_if bif0 ();

   tri1 [7:0] db;
   tri1 [7:0] db0;
   logic       wr_en,  wr_en0;
   logic [7:0] wr_data, wr_data0;

   assign db  = wr_en  ? wr_data  : 8'bz;
   assign db0 = wr_en0 ? wr_data0 : 8'bz;

   javk_mem_responder #(
      .ADDR_BITS   (12),
      .BASE        (16'h0000),
      .WAIT_STATES (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bif.slave),
      .databus (db)
   );

   javk_mem_responder #(
      .ADDR_BITS   (12),
      .BASE        (16'h0000),
      .WAIT_STATES (0)
`ifdef JAVK_MEM_WP_EN
      ,.WP_LIMIT   (16'h0000)
`endif
   ) dut0 (
      .clk     (clk),
      .rst     (rst),
      .bus     (bif0.slave),
      .databus (db0)
   );

   // Low-offset scratch locations move above the protected range when WP is built in.
`ifdef JAVK_MEM_WP_EN
   localparam logic [15:0] A1 = 16'h0210;
   localparam logic [15:0] A4 = 16'h0240;
`else
   localparam logic [15:0] A1 = 16'h0010;
   localparam logic [15:0] A4 = 16'h0040;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One complete handshake; a_late replaces addrbus after the latching edge.
   task automatic access(input bit sel, input string tag, input logic [15:0] a,
                         input logic [15:0] a_late, input logic r, input logic [7:0] wd,
                         input int exp_lat, input logic [7:0] exp_rd, input bit chk_rd,
                         output logic [7:0] rd);
      int         lat;
      logic       ackv;
      logic [7:0] dbv;
      bit         z_ok;
      if (sel) begin
         bif0.addrbus = a; bif0.rw = r; bif0.req = 1'b1; wr_en0 = !r; wr_data0 = wd;
      end else begin
         bif.addrbus = a; bif.rw = r; bif.req = 1'b1; wr_en = !r; wr_data = wd;
      end
      lat  = 0;
      ackv = 1'b0;
      dbv  = 8'h00;
      z_ok = 1'b1;
      while (!ackv && lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
         if (lat == 1) begin
            if (sel) bif0.addrbus = a_late;
            else     bif.addrbus  = a_late;
         end
         @(negedge clk);
         ackv = sel ? bif0.ack : bif.ack;
         dbv  = sel ? db0 : db;
         if (!ackv && r && dbv !== 8'hFF) z_ok = 1'b0;
      end
      check({tag, "_lat"}, lat, exp_lat);
      if (r) check({tag, "_busy_z"}, 32'(z_ok), 1);
      if (chk_rd) check({tag, "_data"}, dbv, exp_rd);
      rd = dbv;
      if (sel) begin
         bif0.req = 1'b0; wr_en0 = 1'b0;
      end else begin
         bif.req = 1'b0; wr_en = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check({tag, "_rel_ack"}, sel ? bif0.ack : bif.ack, 0);
      check({tag, "_rel_z"}, sel ? db0 : db, 8'hFF);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] rd;
      bit         bad;

      rst = 1'b1;
      bif.addrbus  = 16'h0000; bif.rw  = 1'b0; bif.req  = 1'b0;
      bif0.addrbus = 16'h0000; bif0.rw = 1'b0; bif0.req = 1'b0;
      wr_en = 1'b0; wr_data = 8'h00; wr_en0 = 1'b0; wr_data0 = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      check("rst_ack", bif.ack, 0);
      check("rst_db", db, 8'hFF);
      check("rst_wp", bif.wp_err, 0);
      check("rst_ack0", bif0.ack, 0);

      // Window edges: 0x0000-0x0FFF hit, 0x1000 and up miss.
      bif.addrbus = 16'h0FFF; #1 check("hit_top", bif.hit, 1);
      bif.addrbus = 16'h1000; #1 check("hit_above", bif.hit, 0);
      @(negedge clk);
      bif.addrbus = 16'h0000; #1 check("hit_base", bif.hit, 1);
      @(negedge clk);

      // 1: write then read back with W=2 latency (ack after edge N+4).
      access(0, "t1_wr", A1, A1, 1'b0, 8'hA5, 5, 8'h00, 0, rd);
      access(0, "t1_rd", A1, A1, 1'b1, 8'h00, 5, 8'hA5, 1, rd);

      // 2: write/read 0x0123; address change after latch must be ignored.
      access(0, "t2_wr", 16'h0123, 16'h0123, 1'b0, 8'h3C, 5, 8'h00, 0, rd);
      access(0, "t2_rd", 16'h0123, A1, 1'b1, 8'h00, 5, 8'h3C, 1, rd);

      // 3: outside the window nothing answers.
      bif.addrbus = 16'h2000; bif.rw = 1'b1; bif.req = 1'b1;
      @(negedge clk);
      check("t3_hit", bif.hit, 0);
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bif.ack !== 1'b0 || db !== 8'hFF) bad = 1'b1;
      end
      check("t3_quiet", 32'(bad), 0);
      bif.req = 1'b0;
      @(negedge clk);

      // 4: reset during WAIT abandons a pending write.
      access(0, "t4_pre", A4, A4, 1'b0, 8'h11, 5, 8'h00, 0, rd);
      bif.addrbus = A4; bif.rw = 1'b0; bif.req = 1'b1; wr_en = 1'b1; wr_data = 8'hFF;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("t4_rst_ack", bif.ack, 0);
      check("t4_rst_z", db, 8'hFF);
      @(posedge clk);
      #1 rst = 1'b0; bif.req = 1'b0; wr_en = 1'b0;
      @(negedge clk);
      check("t4_post_ack", bif.ack, 0);
      check("t4_post_wp", bif.wp_err, 0);
      access(0, "t4_rd", A4, A4, 1'b1, 8'h00, 5, 8'h11, 1, rd);

      // 5: write protection of offsets below 0x100 (or plain commit without it).
`ifdef JAVK_MEM_WP_EN
      access(0, "t5_wr_prot", 16'h0080, 16'h0080, 1'b0, 8'h55, 5, 8'h00, 0, rd);
      check("t5_wp_set", bif.wp_err, 1);
      access(0, "t5_rd_prot", 16'h0080, 16'h0080, 1'b1, 8'h00, 5, 8'h00, 0, rd);
      check("t5_unchanged", 32'(rd == 8'h55), 0);
`else
      access(0, "t5_wr_low", 16'h0080, 16'h0080, 1'b0, 8'h55, 5, 8'h00, 0, rd);
      check("t5_wp_tied", bif.wp_err, 0);
      access(0, "t5_rd_low", 16'h0080, 16'h0080, 1'b1, 8'h00, 5, 8'h55, 1, rd);
`endif
      access(0, "t5_wr_lim", 16'h0100, 16'h0100, 1'b0, 8'h66, 5, 8'h00, 0, rd);
      access(0, "t5_rd_lim", 16'h0100, 16'h0100, 1'b1, 8'h00, 5, 8'h66, 1, rd);
`ifdef JAVK_MEM_WP_EN
      check("t5_wp_sticky", bif.wp_err, 1);
`else
      check("t5_wp_still0", bif.wp_err, 0);
`endif

      // 6: zero wait states, back-to-back reads one req-low edge apart.
      access(1, "t6_wr0", 16'h0000, 16'h0000, 1'b0, 8'h12, 3, 8'h00, 0, rd);
      access(1, "t6_wr1", 16'h0001, 16'h0001, 1'b0, 8'h34, 3, 8'h00, 0, rd);
      access(1, "t6_rd0", 16'h0000, 16'h0000, 1'b1, 8'h00, 3, 8'h12, 1, rd);
      access(1, "t6_rd1", 16'h0001, 16'h0001, 1'b1, 8'h00, 3, 8'h34, 1, rd);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
